ifu_ir_buffer: RTL and testbench

//  Instruction buffer between the IFU IR-stage output and the EXU input.

---
 rtl/ifu_ir_buffer.sv | 72 +++++++
 tb/tb_ifu_ir_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ifu_ir_buffer.sv
// ifu_ir_buffer: DEPTH-entry instruction FIFO between the IFU IR stage and the EXU, emptied in one cycle by exu_flush.
// Define IFU_IRBUF_BYPASS_EN to forward the IFU entry straight to the EXU while the buffer is empty.
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module ifu_ir_buffer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifu_i_valid,
    output logic                    ifu_i_ready,
    input  logic [`INSTR_SIZE-1:0]  ifu_i_ir,
    input  logic [`PC_SIZE-1:0]     ifu_i_pc,
    input  logic [`RFIDX_WIDTH-1:0] ifu_i_rs1idx,
    input  logic [`RFIDX_WIDTH-1:0] ifu_i_rs2idx,
    input  logic                    ifu_i_prdt_taken,
    output logic                    exu_o_valid,
    input  logic                    exu_o_ready,
    output logic [`INSTR_SIZE-1:0]  exu_o_ir,
    output logic [`PC_SIZE-1:0]     exu_o_pc,
    output logic [`RFIDX_WIDTH-1:0] exu_o_rs1idx,
    output logic [`RFIDX_WIDTH-1:0] exu_o_rs2idx,
    output logic                    exu_o_prdt_taken,
    input  logic                    exu_flush,
    output logic [CNT_W-1:0]        buf_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = `INSTR_SIZE + `PC_SIZE + 2 * `RFIDX_WIDTH + 1;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    din, head;
    logic [PW-1:0]    wptr, rptr;
    logic [CNT_W-1:0] count;
    logic             empty, byp, wr, rd;
    assign din = {ifu_i_ir, ifu_i_pc, ifu_i_rs1idx, ifu_i_rs2idx, ifu_i_prdt_taken};
    assign empty = count == '0;
    assign ifu_i_ready = count != CNT_W'(DEPTH);
`ifdef IFU_IRBUF_BYPASS_EN
    assign byp = empty & ifu_i_valid & !exu_flush;
`else
    assign byp = 1'b0;
`endif
    assign exu_o_valid = !exu_flush & (byp | !empty);
    assign head = exu_o_valid ? (byp ? din : mem[rptr]) : '0;
    assign {exu_o_ir, exu_o_pc, exu_o_rs1idx, exu_o_rs2idx, exu_o_prdt_taken} = head;
    // A bypassed entry taken by the EXU in the same cycle never occupies a slot
    assign wr = ifu_i_valid & ifu_i_ready & !exu_flush & !(byp & exu_o_ready);
    assign rd = exu_o_valid & exu_o_ready & !byp;
    assign buf_count = count;
    always_ff @(posedge clk) begin
        if (rst || exu_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(wr);
            rptr  <= rptr + PW'(rd);
            count <= count + CNT_W'(wr) - CNT_W'(rd);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end
endmodule

// File: tb/tb_ifu_ir_buffer.sv
// tb_ifu_ir_buffer: table vectors, directed stream/bypass sequences and a queue-model random run.
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module tb_ifu_ir_buffer;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;
`ifdef IFU_IRBUF_BYPASS_EN
    localparam bit B = 1'b1;
`else
    localparam bit B = 1'b0;
`endif
    typedef struct packed {
        logic [`INSTR_SIZE-1:0]  ir;
        logic [`PC_SIZE-1:0]     pc;
        logic [`RFIDX_WIDTH-1:0] rs1;
        logic [`RFIDX_WIDTH-1:0] rs2;
        logic                    taken;
    } ent_t;
    typedef struct {
        logic        rst, v, r, f;
        logic [31:0] pc;
        logic        chk, ev, er;
        logic [1:0]  ec;
        logic [31:0] epc;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, ifu_i_valid = 1'b0, exu_o_ready = 1'b0, exu_flush = 1'b0;
    logic ifu_i_ready, exu_o_valid, exu_o_prdt_taken;
    logic [`INSTR_SIZE-1:0]  exu_o_ir;
    logic [`PC_SIZE-1:0]     exu_o_pc;
    logic [`RFIDX_WIDTH-1:0] exu_o_rs1idx, exu_o_rs2idx;
    logic [CNT_W-1:0]        buf_count;
    ent_t din, dout;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;
    assign dout = {exu_o_ir, exu_o_pc, exu_o_rs1idx, exu_o_rs2idx, exu_o_prdt_taken};

    ifu_ir_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ifu_i_valid(ifu_i_valid), .ifu_i_ready(ifu_i_ready),
        .ifu_i_ir(din.ir), .ifu_i_pc(din.pc), .ifu_i_rs1idx(din.rs1), .ifu_i_rs2idx(din.rs2),
        .ifu_i_prdt_taken(din.taken),
        .exu_o_valid(exu_o_valid), .exu_o_ready(exu_o_ready),
        .exu_o_ir(exu_o_ir), .exu_o_pc(exu_o_pc), .exu_o_rs1idx(exu_o_rs1idx), .exu_o_rs2idx(exu_o_rs2idx),
        .exu_o_prdt_taken(exu_o_prdt_taken),
        .exu_flush(exu_flush), .buf_count(buf_count)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.ir = `INSTR_SIZE'(pc ^ 32'h0000_0013);
        e.pc = `PC_SIZE'(pc);
        e.rs1 = pc[6:2];
        e.rs2 = pc[11:7];
        e.taken = pc[3];
        return e;
    endfunction

    function automatic vec_t mkv(input logic r_, v, rd, f, input logic [31:0] pc,
                                 input logic c, ev, er, input logic [1:0] ec, input logic [31:0] epc);
        vec_t t;
        t.rst = r_; t.v = v; t.r = rd; t.f = f; t.pc = pc;
        t.chk = c; t.ev = ev; t.er = er; t.ec = ec; t.epc = epc;
        return t;
    endfunction

    task automatic drive(input logic r_, v, rd, f, input ent_t e);
        rst = r_; ifu_i_valid = v; exu_o_ready = rd; exu_flush = f; din = e;
    endtask

    localparam logic [31:0] P0 = 32'h8000_0000, P1 = 32'h8000_0004, P2 = 32'h8000_0008;
    vec_t tv[16];
    ent_t q[$];

    initial begin
        logic        ev, bp;
        ent_t        eh;
        logic [31:0] base;
        din = '0;
        // rst, valid, ready, flush, pc | check, exp valid, exp ready, exp count, exp pc
        tv[0]  = mkv(1, 0, 0, 0, 0,  0, 0, 1, 0, 0);
        tv[1]  = mkv(1, 0, 0, 0, 0,  1, 0, 1, 0, 0);
        tv[2]  = mkv(0, 1, 0, 0, P0, 1, B, 1, 0, B ? P0 : 32'h0);
        tv[3]  = mkv(0, 1, 0, 0, P1, 1, 1, 1, 1, P0);
        tv[4]  = mkv(0, 1, 0, 0, P2, 1, 1, 0, 2, P0);
        tv[5]  = mkv(0, 1, 0, 0, P2, 1, 1, 0, 2, P0);
        tv[6]  = mkv(0, 1, 1, 0, P2, 1, 1, 0, 2, P0);
        tv[7]  = mkv(0, 0, 1, 0, 0,  1, 1, 1, 1, P1);
        tv[8]  = mkv(0, 0, 1, 0, 0,  1, 0, 1, 0, 0);
        tv[9]  = mkv(0, 1, 0, 0, P0, 1, B, 1, 0, B ? P0 : 32'h0);
        tv[10] = mkv(0, 1, 0, 0, P1, 1, 1, 1, 1, P0);
        tv[11] = mkv(0, 1, 1, 1, P2, 1, 0, 0, 2, 0);
        tv[12] = mkv(0, 0, 1, 0, 0,  1, 0, 1, 0, 0);
        tv[13] = mkv(0, 1, 0, 0, P0, 1, B, 1, 0, B ? P0 : 32'h0);
        tv[14] = mkv(1, 1, 0, 0, P1, 1, 1, 1, 1, P0);
        tv[15] = mkv(0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].v, tv[i].r, tv[i].f, mk(tv[i].pc));
            #2;
            if (tv[i].chk) begin
                chk($sformatf("tv%0d_valid", i), 128'(exu_o_valid), 128'(tv[i].ev));
                chk($sformatf("tv%0d_ready", i), 128'(ifu_i_ready), 128'(tv[i].er));
                chk($sformatf("tv%0d_count", i), 128'(buf_count), 128'(tv[i].ec));
                chk($sformatf("tv%0d_pc", i), 128'(exu_o_pc), 128'(tv[i].epc));
            end
        end
        // steady stream from empty: one bubble without bypass, none with it
        base = 32'h8000_0100;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(0, 1, 1, 0, mk(base + 32'(4 * k)));
            #2;
            chk($sformatf("stream%0d_valid", k), 128'(exu_o_valid), 128'(B || k > 0));
            chk($sformatf("stream%0d_count", k), 128'(buf_count), 128'((B || k == 0) ? 0 : 1));
            if (B || k > 0)
                chk($sformatf("stream%0d_ent", k), 128'(dout), 128'(mk(base + 32'(4 * (B ? k : k - 1)))));
        end
        @(negedge clk);
        drive(0, 0, 1, 0, '0);
        #2;
        chk("stream_tail_count", 128'(buf_count), 128'(B ? 0 : 1));
        @(negedge clk);
        #2;
        chk("stream_empty_count", 128'(buf_count), 128'(0));
        // empty buffer, EXU ready: same-cycle delivery only with bypass
        @(negedge clk);
        drive(0, 1, 1, 0, mk(32'h8000_0010));
        #2;
        chk("byp_valid", 128'(exu_o_valid), 128'(B));
        chk("byp_pc", 128'(exu_o_pc), 128'(B ? 32'h8000_0010 : 32'h0));
        @(negedge clk);
        drive(0, 0, 1, 0, '0);
        #2;
        chk("byp_next_valid", 128'(exu_o_valid), 128'(!B));
        chk("byp_next_pc", 128'(exu_o_pc), 128'(B ? 32'h0 : 32'h8000_0010));
        chk("byp_next_count", 128'(buf_count), 128'(B ? 0 : 1));
        // randomized run against a queue model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            eh = mk($urandom);
            eh.ir = `INSTR_SIZE'($urandom);
            eh.taken = 1'($urandom_range(0, 1));
            drive(n == 0 || $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, eh);
            #2;
            bp = B && q.size() == 0 && ifu_i_valid && !exu_flush;
            ev = !exu_flush && (q.size() > 0 || bp);
            if (n > 0) begin
                chk("rnd_valid", 128'(exu_o_valid), 128'(ev));
                chk("rnd_ready", 128'(ifu_i_ready), 128'(q.size() != DEPTH));
                chk("rnd_count", 128'(buf_count), 128'(q.size()));
                chk("rnd_ent", 128'(dout), ev ? 128'(bp ? din : q[0]) : 128'(0));
            end
            if (rst || exu_flush) q.delete();
            else begin
                if (ifu_i_valid && q.size() != DEPTH) q.push_back(din);
                if (ev && exu_o_ready) void'(q.pop_front());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
